bus_cycle_ctrl: RTL
===================

// Module: bus_cycle_ctrl
// PURPOSE
//   Sequences one minimum-mode external bus cycle (T1-T2-T3-[Tw]-T4) per request from the bus interface unit.
//   Multiplexes address and data onto the AD/AS pads and generates ale, rd_n, wr_n, m_n, bhe_n, den_n and dt.
//   Grants the bus to an external master via hold/hlda.
//   Sits between the BIU prefetch/EU request port and the top-level pad tristate buffers.
// PARAMETERS
//   WAIT_LIMIT  0  max consecutive Tw states before forced abort; 0 = unlimited
//   WCNT_W      8  width of wait counter (must hold WAIT_LIMIT)
// PORTS
//   clk        in   1   clock
//   rst        in   1   synchronous reset, active-high
//   req        in   1   request valid; held high until ack
//   req_we     in   1   1 = write, 0 = read
//   req_io     in   1   1 = IO space, 0 = memory
//   req_byte   in   1   1 = byte transfer, 0 = word
//   req_seg    in   2   segment code driven on S4:S3
//   req_addr   in   20  physical address
//   req_wdata  in   16  write data (byte in [7:0])
//   ack        out  1   one-cycle pulse in T4: cycle done
//   err        out  1   valid with ack: wait-limit abort
//   rdata      out  16  read data, valid with ack, held until next ack
//   ad_in      in   16  AD pad input
//   ad_out     out  16  AD pad output
//   ad_oe      out  1   AD pad output enable
//   as_out     out  4   A19:16 in T1, status S6:S3 otherwise
//   ctl_oe     out  1   enable for as/ale/rd_n/wr_n/m_n/bhe_n/den_n/dt pads
//   ale, rd_n, wr_n, m_n, bhe_n, den_n, dt   out 1 each  bus strobes
//   rdy        in   1   ready from memory/IO
//   hold       in   1   external bus request
//   hlda       out  1   hold acknowledge
// BEHAVIOUR
//   Reset values: state IDLE, ale=0, rd_n=1, wr_n=1, den_n=1, dt=0, m_n=0, bhe_n=1, ad_oe=0.
//   Further reset values: ctl_oe=1, hlda=0, ack=0, err=0, rdata=0, wait count 0.
//   Reset mid-cycle returns to IDLE next edge; strobes deassert and no ack is issued.
//   States IDLE, T1, T2, T3, TW, T4, HOLD. Outputs decode from registered state and latched request.
//   IDLE -> HOLD if hold=1 (hold wins over simultaneous req).
//   IDLE -> T1 if req=1; latch we/io/byte/seg/addr/wdata on that edge.
//   T1: ale=1, ad_oe=1, ad_out=addr[15:0], as_out=addr[19:16], m_n=io, dt=we, bhe_n driven.
//   T1 -> T2.
//   T2: ale=0, den_n=0, as_out={2'b00,seg}.
//   T2 read: ad_oe=0, rd_n=0. T2 write: ad_oe=1, ad_out=write data, wr_n=0. T2 -> T3.
//   T3/TW: same outputs as T2. rdy is sampled only in T3/TW. rdy=1 -> T4, capturing ad_in on a read.
//   rdy=0 -> TW and wait count +1.
//   WAIT_LIMIT>0 and wait count==WAIT_LIMIT with rdy=0 -> T4 with err=1 and rdata=16'hFFFF.
//   T4: rd_n=wr_n=1, den_n=1, ad_oe=0, ack=1. T4 -> IDLE always; wait count clears.
//   HOLD: hlda=1, ctl_oe=0, ad_oe=0. HOLD -> IDLE when hold=0; hlda falls on that edge.
//   hold is ignored in T1-T4; the cycle always completes first.
//   Latency: req at edge n -> T1 n+1, T2 n+2, T3 n+3, T4/ack n+4 with zero waits. Each Tw adds 1.
//   bhe_n = req_byte & ~addr[0], i.e. 0 for a word or an odd byte.
//   Odd-address word cycles are not split here; the requester splits them.
//   Byte write data on AD: {wdata[7:0],wdata[7:0]}.
//   Read data: word -> ad_in; odd byte -> {8'h00,ad_in[15:8]}; even byte -> {8'h00,ad_in[7:0]}.
// TESTING
//   1. Mem word read 0x12344, rdy=1, ad_in=16'hBEEF: ale only in T1 with ad_out=0x2344, as_out=0x1.
//      Then rd_n low T2-T3, ack at n+4, rdata=0xBEEF, bhe_n=0, m_n=0.
//   2. IO byte write addr 0x00061, wdata 0x5A: m_n=1, dt=1, bhe_n=0, T2-T3 ad_out=0x5A5A, wr_n low 2 cycles, ack n+4.
//   3. Mem read with rdy low 3 cycles: 3 TW states, ack at n+7.
//      With WAIT_LIMIT=2 and rdy stuck low: ack at n+6, err=1, rdata=0xFFFF.
//   4. hold and req both high in IDLE: HOLD entered, hlda=1, ctl_oe=0.
//      hold drops: IDLE, then T1 next cycle. hold raised in T2: cycle completes and ack issued before hlda.
//   5. rst asserted in T3 of a write: wr_n=1, den_n=1, ad_oe=0 next cycle, no ack, state IDLE.
//   6. Even byte read, ad_in=0xA1B2: rdata=0x00B2, bhe_n=1. Odd byte read, same ad_in: rdata=0x00A1.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// Minimum-mode external bus cycle sequencer: T1-T2-T3-[Tw]-T4 per request,
// AD/AS pad multiplexing, bus strobes and hold/hlda bus grant.
module bus_cycle_ctrl #(
   parameter int unsigned WAIT_LIMIT = 0,  // 0 = unlimited wait states
   parameter int unsigned WCNT_W     = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   // Request port from BIU
   input  logic        req_i,
   input  logic        req_we_i,
   input  logic        req_io_i,
   input  logic        req_byte_i,
   input  logic [1:0]  req_seg_i,
   input  logic [19:0] req_addr_i,
   input  logic [15:0] req_wdata_i,
   output logic        ack_o,
   output logic        err_o,
   output logic [15:0] rdata_o,
   // Pads
   input  logic [15:0] ad_in_i,
   output logic [15:0] ad_out_o,
   output logic        ad_oe_o,
   output logic [3:0]  as_out_o,
   output logic        ctl_oe_o,
   output logic        ale_o,
   output logic        rd_n_o,
   output logic        wr_n_o,
   output logic        m_n_o,
   output logic        bhe_n_o,
   output logic        den_n_o,
   output logic        dt_o,
   input  logic        rdy_i,
   input  logic        hold_i,
   output logic        hlda_o
);

   localparam logic [2:0] StIdle = 3'd0;
   localparam logic [2:0] StT1   = 3'd1;
   localparam logic [2:0] StT2   = 3'd2;
   localparam logic [2:0] StT3   = 3'd3;
   localparam logic [2:0] StTw   = 3'd4;
   localparam logic [2:0] StT4   = 3'd5;
   localparam logic [2:0] StHold = 3'd6;

   localparam logic [WCNT_W-1:0] WaitLimitW = WCNT_W'(WAIT_LIMIT);

   logic [2:0]        state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              we_q, io_q, byte_q;
   logic [1:0]        seg_q;
   logic [19:0]       addr_q;
   logic [15:0]       wdata_q;
   logic [15:0]       rdata_q;
   logic              err_q;

   logic              lat_en;
   logic              rd_cap;
   logic              abort;
   logic [15:0]       rd_fmt;

   // Next-state, wait counting and capture strobes
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      lat_en  = 1'b0;
      rd_cap  = 1'b0;
      abort   = 1'b0;
      case (state_q)
         StIdle: begin
            // hold takes priority over a simultaneous request
            if (hold_i) begin
               state_d = StHold;
            end else if (req_i) begin
               state_d = StT1;
               lat_en  = 1'b1;
            end
         end
         StT1: state_d = StT2;
         StT2: state_d = StT3;
         StT3, StTw: begin
            if (rdy_i) begin
               state_d = StT4;
               rd_cap  = ~we_q;
            end else if ((WAIT_LIMIT != 0) && (wcnt_q == WaitLimitW)) begin
               state_d = StT4;
               abort   = 1'b1;
            end else begin
               state_d = StTw;
               if (wcnt_q != '1) begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         StT4: begin
            state_d = StIdle;
            wcnt_d  = '0;
         end
         StHold: begin
            if (!hold_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Read data lane steering for byte transfers
   always_comb begin
      rd_fmt = ad_in_i;
      if (byte_q) begin
         rd_fmt = addr_q[0] ? {8'h00, ad_in_i[15:8]} : {8'h00, ad_in_i[7:0]};
      end
   end

   // State, latched request, wait count and read result registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         wcnt_q  <= '0;
         we_q    <= 1'b0;
         io_q    <= 1'b0;
         byte_q  <= 1'b0;
         seg_q   <= 2'b00;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         // abort only fires on the edge entering T4, so err_q is high just in T4
         err_q   <= abort;
         if (lat_en) begin
            we_q    <= req_we_i;
            io_q    <= req_io_i;
            byte_q  <= req_byte_i;
            seg_q   <= req_seg_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
         if (abort) begin
            rdata_q <= 16'hFFFF;
         end else if (rd_cap) begin
            rdata_q <= rd_fmt;
         end
      end
   end

   logic is_t1, data_ph, in_cycle, is_hold;
   logic [15:0] wbus;

   // Pad and strobe decode from registered state and latched request
   always_comb begin
      is_t1    = (state_q == StT1);
      data_ph  = (state_q == StT2) || (state_q == StT3) || (state_q == StTw);
      in_cycle = is_t1 || data_ph || (state_q == StT4);
      is_hold  = (state_q == StHold);
      wbus     = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;

      ad_out_o = is_t1 ? addr_q[15:0] : wbus;
      ad_oe_o  = is_t1 || (data_ph && we_q);
      as_out_o = is_t1 ? addr_q[19:16] : {2'b00, seg_q};
      ale_o    = is_t1;
      rd_n_o   = ~(data_ph && !we_q);
      wr_n_o   = ~(data_ph && we_q);
      den_n_o  = ~data_ph;
      dt_o     = in_cycle && we_q;
      m_n_o    = in_cycle && io_q;
      bhe_n_o  = in_cycle ? (byte_q && !addr_q[0]) : 1'b1;
      ctl_oe_o = ~is_hold;
      hlda_o   = is_hold;
      ack_o    = (state_q == StT4);
      err_o    = err_q;
      rdata_o  = rdata_q;
   end

endmodule
